gpio_mmio_dev: RTL
==================

// Module: gpio_mmio_dev
// PURPOSE
//  Parametrised memory-mapped GPIO peripheral replacing the separate LED/slide/button devices.
//  Drives NOUT output pins from a register and debounces NIN input pins (2-FF sync + stable counter).
//  Latches sticky per-channel edge flags and raises a maskable level IRQ.
//  Sits behind the address decoder on the single-cycle MIPS data bus; read data is combinational, writes commit on clk.
// PARAMETERS
//  NIN        4   number of input channels (1..32)
//  NOUT       8   number of output channels (1..32)
//  DEB_CYCLES 16  consecutive stable synchronised samples required to accept a new input level (>=1)
//  EDGE_MODE  2   0 = rising only, 1 = falling only, 2 = both edges set EDGE flags
// PORTS
//  clk      in   1     system clock, all state on rising edge
//  reset    in   1     asynchronous, active-high; clears all state
//  sel      in   1     chip select from address decoder
//  we       in   1     write strobe (qualified by sel)
//  addr     in   2     word offset = dataadr[3:2]
//  wdata    in   32    write data
//  rdata    out  32    read data, combinational from addr; zero-extended; valid regardless of sel
//  pin_in   in   NIN   asynchronous external inputs (switches, buttons)
//  pin_out  out  NOUT  registered outputs = OUT register
//  irq      out  1     |(EDGE & MASK), registered-state derived, combinational from registers
// BEHAVIOUR
//  Register map, write = sel & we at rising clk:
//   0 OUT  R/W  [NOUT-1:0]; rdata returns OUT
//   1 IN   RO   [NIN-1:0]; debounced levels; writes ignored
//   2 EDGE R/W1C [NIN-1:0]; sticky; write 1 clears bit, write 0 no effect
//   3 MASK R/W  [NIN-1:0] irq enable
//  Reset values: OUT=0, MASK=0, EDGE=0, debounced levels=0, sync FFs=0, counters=0; pin_out=0, irq=0, rdata=OUT=0 at addr 0.
//  Input path per channel: s1<=pin_in, s2<=s1; if s2==deb level, count<=0; else count<=count+1
//   and when count reaches DEB_CYCLES-1 (i.e. the DEB_CYCLES-th differing sample), deb<=s2, count<=0.
//   A glitch shorter than DEB_CYCLES samples resets count on return and never changes deb.
//  Latency: clean pin step to IN change = 2 (sync) + DEB_CYCLES cycles.
//  Edge detect: when deb changes 0->1 (rise) or 1->0 (fall), matching EDGE_MODE sets EDGE[i] the same cycle deb updates.
//  Simultaneous W1C clear and new edge on the same bit in one cycle: set wins, EDGE[i]=1.
//  Clearing a bit not set and setting others in the same cycle are independent per bit.
//  irq reflects EDGE/MASK the cycle after they update; writing MASK=0 drops irq without clearing EDGE.
//  Bits of wdata above NOUT/NIN are ignored; unread upper rdata bits are 0.
//  Reset asserted mid-debounce discards partial counts; after release deb=0, so a held-high pin
//   generates a rise edge after 2+DEB_CYCLES cycles (EDGE_MODE 0/2).
//  Counter width = clog2(DEB_CYCLES+1); no wrap possible since count clears at threshold.
// STRUCTURE
//  Shared package gpio_pkg: register offsets GPIO_OUT=0, GPIO_IN=1, GPIO_EDGE=2, GPIO_MASK=3;
//   edge mode constants EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2.
//  Sub-module gpio_debounce (one channel: sync, counter, deb, rise/fall pulses), generated NIN times.
//  Top holds OUT/EDGE/MASK registers, read mux, irq reduction; top-level SoC ties led=pin_out[7:0].
// TESTING
//  Reset then read all 4 offsets -> 0; pin_out=0, irq=0; assert reset mid-run -> all regs 0 asynchronously.
//  Write OUT=0xA5 (NOUT=8) -> pin_out=0xA5 next cycle, read addr0=0x000000A5; write with sel=0 -> unchanged.
//  DEB_CYCLES=16: pin_in[0] high for 10 cycles then low -> IN stays 0, EDGE stays 0;
//   held high -> IN[0]=1 exactly 18 cycles after step.
//  EDGE_MODE=2, MASK=0x1: press/release pin 0 -> EDGE=0x1 and irq=1 after rise; write EDGE=0x1 -> 0, irq=0;
//   release -> set again.
//  Clear EDGE[1] in same cycle its rise is accepted -> EDGE[1]=1 (set wins); write EDGE=0x0 -> no change.
//  EDGE_MODE=0: falling transition -> EDGE unchanged; MASK=0 with EDGE=0xF -> irq=0, EDGE reads 0xF.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared definitions for the memory-mapped GPIO peripheral.
// Contents: register word offsets (as an enum) and edge-detection mode constants.
// No ports; imported by the GPIO top level and its testbench.
package gpio_pkg;

   // Word offsets within the peripheral, taken from dataadr[3:2].
   typedef enum logic [1:0] {
      GPIO_OUT  = 2'd0,
      GPIO_IN   = 2'd1,
      GPIO_EDGE = 2'd2,
      GPIO_MASK = 2'd3
   } gpio_reg_e;

   // Which debounced transitions set the sticky EDGE flags.
   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_BOTH = 2;

endpackage

// File: rtl/gpio_mmio_dev_if.sv
// Data-bus interface between the address decoder / CPU and the GPIO peripheral.
// Signals: sel (chip select), we (write strobe), addr (word offset), wdata, rdata.
// master = bus driver (CPU side), slave = peripheral side; rdata is combinational.
interface gpio_mmio_dev_if;
   logic        sel;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output sel, output we, output addr, output wdata, input rdata);
   modport slave  (input sel, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/gpio_debounce.sv
// One input channel: two-flop synchroniser, stable-sample counter and debounced level.
// Ports: clk, reset (async, active-high), pin_i (asynchronous pin), deb_o (debounced level),
//        rise_o / fall_o (single-cycle pulses asserted in the cycle deb_o is about to change).
module gpio_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic pin_i,
   output logic deb_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          s1_q, s2_q;
   logic          deb_q, deb_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         deb_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_q  <= pin_i;
         s2_q  <= s1_q;
         deb_q <= deb_d;
         cnt_q <= cnt_d;
      end
   end

   // Any sample agreeing with the current level restarts the count, so a glitch
   // shorter than DEB_CYCLES samples can never move deb. The DEB_CYCLES-th
   // consecutive differing sample is accepted; the counter clears there, so it
   // never needs to wrap.
   always_comb begin
      cnt_d  = cnt_q;
      deb_d  = deb_q;
      rise_o = 1'b0;
      fall_o = 1'b0;
      if (s2_q == deb_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         deb_d  = s2_q;
         cnt_d  = '0;
         rise_o = s2_q;
         fall_o = ~s2_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   assign deb_o = deb_q;

endmodule

// File: rtl/gpio_mmio_dev.sv
// Memory-mapped GPIO: OUT register drives pins, debounced inputs, sticky edge flags, maskable IRQ.
// Ports: clk, reset (async, active-high), bus (slave: sel/we/addr/wdata in, rdata out),
//        pin_in[NIN] (async inputs), pin_out[NOUT] (= OUT register), irq (= |(EDGE & MASK)).
module gpio_mmio_dev
   import gpio_pkg::*;
#(
   parameter int NIN        = 4,
   parameter int NOUT       = 8,
   parameter int DEB_CYCLES = 16,
   parameter int EDGE_MODE  = EDGE_BOTH
) (
   input  logic              clk,
   input  logic              reset,
   gpio_mmio_dev_if.slave    bus,
   input  logic [NIN-1:0]    pin_in,
   output logic [NOUT-1:0]   pin_out,
   output logic              irq
);

   logic [NOUT-1:0] out_q, out_d;
   logic [NIN-1:0]  edge_q, edge_d;
   logic [NIN-1:0]  mask_q, mask_d;

   logic [NIN-1:0]  deb_lvl;
   logic [NIN-1:0]  rise;
   logic [NIN-1:0]  fall;
   logic [NIN-1:0]  edge_set;
   logic [NIN-1:0]  edge_clr;
   logic [31:0]     rdata_v;
   logic            wr;
   gpio_reg_e       reg_sel;

   // Upper wdata bits beyond NOUT/NIN are deliberately ignored.
   wire unused_wdata = ^bus.wdata;

   for (genvar i = 0; i < NIN; i++) begin : g_in
      gpio_debounce #(
         .DEB_CYCLES (DEB_CYCLES)
      ) u_deb (
         .clk    (clk),
         .reset  (reset),
         .pin_i  (pin_in[i]),
         .deb_o  (deb_lvl[i]),
         .rise_o (rise[i]),
         .fall_o (fall[i])
      );
   end

   assign wr      = bus.sel & bus.we;
   assign reg_sel = gpio_reg_e'(bus.addr);

   assign edge_set = ((EDGE_MODE != EDGE_FALL) ? rise : '0)
                   | ((EDGE_MODE != EDGE_RISE) ? fall : '0);
   assign edge_clr = (wr && reg_sel == GPIO_EDGE) ? bus.wdata[NIN-1:0] : '0;

   always_comb begin
      out_d  = out_q;
      mask_d = mask_q;
      if (wr && reg_sel == GPIO_OUT)  out_d  = bus.wdata[NOUT-1:0];
      if (wr && reg_sel == GPIO_MASK) mask_d = bus.wdata[NIN-1:0];
      // Set is applied after clear so a new edge wins over a simultaneous W1C.
      edge_d = (edge_q & ~edge_clr) | edge_set;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q  <= '0;
         edge_q <= '0;
         mask_q <= '0;
      end else begin
         out_q  <= out_d;
         edge_q <= edge_d;
         mask_q <= mask_d;
      end
   end

   // Read data is decoded regardless of sel; the SoC read mux qualifies it.
   always_comb begin
      rdata_v = '0;
      case (reg_sel)
         GPIO_OUT:  rdata_v[NOUT-1:0] = out_q;
         GPIO_IN:   rdata_v[NIN-1:0]  = deb_lvl;
         GPIO_EDGE: rdata_v[NIN-1:0]  = edge_q;
         GPIO_MASK: rdata_v[NIN-1:0]  = mask_q;
      endcase
   end

   assign bus.rdata = rdata_v;
   assign pin_out   = out_q;
   assign irq       = |(edge_q & mask_q);

endmodule
